// File: rtl/frame_pkg.sv
// frame_pkg: shared FSM encodings and defaults for frame capture blocks (PARITY state under FRAME_CAPTURE_PARITY_CHECK_EN)
package frame_pkg;
    localparam int PAYLOAD_W_DEF = 8;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/frame_out_buf.sv
// frame_out_buf: single-entry output holding register with valid/ready handshake and drop detection
module frame_out_buf import frame_pkg::*; #(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] frame,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    output logic                 overflow
);
    logic room;
    assign room = !out_valid || out_ready;
    // load a finished frame when the slot is free or draining, otherwise drop it and flag overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_data  <= (load && room) ? frame : out_data;
            out_valid <= (load && room) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
            overflow  <= load && !room;
        end
    end
endmodule

// File: rtl/frame_capture.sv
// frame_capture: shifts in a payload after each sync pulse and hands it to the output buffer; optional even parity via FRAME_CAPTURE_PARITY_CHECK_EN
module frame_capture import frame_pkg::*; #(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data,
    input  logic                 sync_det,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic                 parity_err
);
    localparam int CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [PAYLOAD_W-1:0] sr, sr_n;
    logic                 done, done_n;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
    logic                 perr, perr_n;
`endif
    // state, counter, shifter and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            done  <= 1'b0;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
            perr  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            done  <= done_n;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
            perr  <= perr_n;
`endif
        end
    end
    // next state: sync only honoured in IDLE; last payload bit (or parity bit) ends the frame
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        done_n  = 1'b0;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sync_det) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                sr_n  = PAYLOAD_W'({sr, data});
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PAYLOAD_W - 1)) begin
                    cnt_n   = '0;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
                    state_n = PARITY;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end
            end
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
            PARITY: begin
                state_n = IDLE;
                done_n  = ~^{sr, data};
                perr_n  = ^{sr, data};
            end
`endif
            default: state_n = IDLE;
        endcase
    end
    assign busy = (state != IDLE);
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
    assign parity_err = perr;
`else
    assign parity_err = 1'b0;
`endif
    frame_out_buf #(.PAYLOAD_W(PAYLOAD_W)) u_buf (
        .clk(clk),
        .rst_n(rst_n),
        .load(done),
        .frame(sr),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .overflow(overflow)
    );
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: scenario tasks plus a queue scoreboard of accepted frames
module tb_frame_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data = 1'b0;
    logic       sync_det = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, busy, overflow, parity_err;
    int         total = 0;
    int         bad = 0;
    int         ovf_cnt = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    frame_capture #(.PAYLOAD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .sync_det(sync_det),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow(overflow), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back(out_data);
        if (overflow) ovf_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input logic par, input bit glitch);
        sync_det = 1'b1;
        tick();
        for (int i = 7; i >= 0; i--) begin
            data = v[i];
            sync_det = glitch ? 1'($urandom) : 1'b0;
            tick();
        end
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
        data = par;
        sync_det = glitch ? 1'($urandom) : 1'b0;
        tick();
`else
        data = par;
`endif
        sync_det = 1'b0;
        data = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({out_valid, busy, overflow, parity_err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {out_valid, busy, overflow, parity_err});
        end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [7:0] v;
        v = 8'hB2;
        out_ready = 1'b1;
        sync_det = 1'b1;
        tick();
        sync_det = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        for (int i = 7; i >= 0; i--) begin
            data = v[i];
            tick();
        end
        data = 1'b0;
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
        data = ^v;
        tick();
        data = 1'b0;
`endif
        total++;
        if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL basic_done got=%b want=00", {busy, out_valid}); end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
            bad++;
            $display("FAIL basic_out got=%b/%h want=1/b2", out_valid, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", out_valid); end
    endtask

    task automatic test_overflow;
        int c0;
        out_ready = 1'b0;
        send(8'hA5, ^8'hA5, 1'b0);
        tick();
        c0 = ovf_cnt;
        send(8'h3C, ^8'h3C, 1'b0);
        tick();
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
        tick();
        total++;
        if (ovf_cnt - c0 !== 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", ovf_cnt - c0); end
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL ovf_hold got=%b/%h want=1/a5", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_accept_load;
        int c0;
        out_ready = 1'b0;
        send(8'hA5, ^8'hA5, 1'b0);
        tick();
        send(8'h3C, ^8'h3C, 1'b0);
        out_ready = 1'b1;
        c0 = ovf_cnt;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || overflow !== 1'b0) begin
            bad++;
            $display("FAIL acc_load got=%b/%h/%b want=1/3c/0", out_valid, out_data, overflow);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || ovf_cnt !== c0) begin
            bad++;
            $display("FAIL acc_after got=%b/%0d want=0/%0d", out_valid, ovf_cnt, c0);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(8'h5A, ^8'h5A, 1'b0);
        tick();
        sync_det = 1'b1;
        tick();
        sync_det = 1'b0;
        repeat (4) begin
            data = 1'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, overflow, parity_err} !== 4'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL rstmid got=%b/%h want=0000/00", {out_valid, busy, overflow, parity_err}, out_data);
        end
        tick();
        rst_n = 1'b1;
        data = 1'b0;
        tick();
        got.delete();
        out_ready = 1'b1;
        send(8'h0F, ^8'h0F, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
            bad++;
            $display("FAIL rstmid_next got=%b/%h want=1/0f", out_valid, out_data);
        end
        tick();
        total++;
        if (got.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", got.size()); end
    endtask

    task automatic test_sync_ignore;
        out_ready = 1'b1;
        send(8'hFF, 1'b0, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            bad++;
            $display("FAIL syncign got=%b/%h want=1/ff", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        out_ready = 1'b1;
        got.delete();
        exp_q.delete();
        for (int n = 0; n < 16; n++) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            send(v, ^v, 1'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (3) tick();
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got.size(); n++) begin
            total++;
            if (got[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL b2b_frame%0d got=%h want=%h", n, got[n], exp_q[n]);
            end
        end
    endtask

`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
    task automatic test_parity;
        out_ready = 1'b1;
        send(8'h01, 1'b1, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL par_ok got=%b/%h/%b want=1/01/0", out_valid, out_data, parity_err);
        end
        tick();
        send(8'h01, 1'b0, 1'b0);
        total++;
        if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err got=%b want=1", parity_err); end
        tick();
        total++;
        if ({parity_err, out_valid, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL par_drop got=%b want=000", {parity_err, out_valid, overflow});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_accept_load();
        test_reset_mid();
        test_sync_ignore();
        test_back_to_back();
`ifdef FRAME_CAPTURE_PARITY_CHECK_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
